sha256_host_seq: RTL
====================

# sha256_host_seq

Host-side sequencer for `simplified_sha256`. It owns the shared single-port memory when the core is idle. On each `go` it:

- writes a seed-derived message into memory;
- pulses the core's `start` and hands the memory port to the core until `done`;
- reads the 8-word digest back and streams it out over a valid/ready port.

It also measures core latency in cycles and flags a hung core.

## Interface

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words (2..64)
- MESSAGE_ADDR, 16'd0, base address of message; driven on `message_addr`
- OUTPUT_ADDR, 16'd1000, base address of digest; driven on `output_addr`
- TIMEOUT, 100000, maximum WAIT cycles before `timeout_err`

Ports:
- clk  in  1  clock; memory and core share it
- reset_n  in  1  reset, synchronous, active-low
- go  in  1  start request, sampled in IDLE only
- seed  in  32  message seed, captured on accepted `go`
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; cleared by the next accepted `go`
- cycle_count  out  32  core latency of the last run
- message_addr  out  16  constant MESSAGE_ADDR
- output_addr  out  16  constant OUTPUT_ADDR
- core_start  out  1  start pulse to core
- core_done  in  1  core completion
- core_mem_we  in  1  core memory write enable
- core_mem_addr  in  16  core memory address
- core_mem_write_data  in  32  core memory write data
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_write_data  out  32  memory write data
- mem_read_data  in  32  memory read data; synchronous read, valid the cycle after the address
- dig_valid  out  1  digest word valid
- dig_ready  in  1  digest word accepted
- dig_data  out  32  digest word H[dig_index]
- dig_index  out  3  digest word index, 0..7
- dig_last  out  1  high with index 7

## Operation

States: IDLE, GEN, START, WAIT, RD_REQ, OUT.

- **IDLE**
  - `go`=1 → GEN.
  - Captures `seed` into word register `w`, clears word counter `k` and `timeout_err`.
- **GEN**
  - One write per cycle: `mem_we`=1, `mem_addr`=MESSAGE_ADDR+k, `mem_write_data`=`w`.
  - Word value is `w`, except k=NUM_OF_WORDS-1, which writes 32'h0.
  - Then `w` ← rotate-left-by-1(`w`), k++.
  - After k=NUM_OF_WORDS-1 → START.
- **START**
  - `core_start`=1 for exactly this one cycle; `mem_we`=0.
  - `cycle_count` ← 1.
  - → WAIT.
- **WAIT**
  - `mem_we`, `mem_addr`, `mem_write_data` are combinationally `core_mem_*`.
  - `cycle_count` increments each cycle, including the cycle `core_done` is sampled high.
  - `core_done`=1 → RD_REQ with i=0.
  - TIMEOUT WAIT cycles without `core_done` → set `timeout_err`, → IDLE with no digest output.
- **RD_REQ**
  - `mem_we`=0, `mem_addr`=OUTPUT_ADDR+i.
  - → OUT.
- **OUT**
  - On entry, `dig_data` ← `mem_read_data`, `dig_index`=i, `dig_valid`=1.
  - `dig_data` is held stable until `dig_valid`&&`dig_ready`.
  - On the handshake: i=7 → IDLE; otherwise i++ → RD_REQ.
- Outside WAIT and GEN: `mem_we`=0 and `mem_addr` is the host value (RD_REQ address, else 0). Core memory outputs are ignored.
- `core_done` is ignored outside WAIT.
- `go` is ignored while `busy`.
- `cycle_count` is frozen outside START/WAIT. It keeps its value across a timeout.
- Arithmetic: address sums are 16-bit and wrap modulo 2^16. `cycle_count` saturates at 32'hFFFFFFFF.

## Timing

- Reset (synchronous, any state, mid-operation included):
  - State → IDLE.
  - Low: `busy`, `core_start`, `mem_we`, `dig_valid`, `timeout_err`, `dig_last`.
  - Zero: `cycle_count`, `dig_data`, `dig_index`, `mem_addr`, `mem_write_data`.
- Run timeline:
  - `go` sampled in cycle 0; GEN occupies cycles 1..NUM_OF_WORDS.
  - START is cycle NUM_OF_WORDS+1. `busy` rises in cycle 1.
  - The first WAIT cycle is the cycle after START.
  - From the cycle `core_done` is sampled to first `dig_valid`: 2 cycles (RD_REQ, then OUT).
- Each digest word takes at least 2 cycles (RD_REQ + OUT). With `dig_ready` tied high, 8 words take 16 cycles.
- `busy` falls the cycle after the handshake on index 7.
- `dig_valid` never drops without a handshake, except on reset.

## Test plan

- **Message generation:** seed=32'h01234567, core stubbed → memory receives 0:01234567, 1:02468ace, 2:048d159c, 18:rotl18 value, 19:00000000. Exactly 20 write cycles, then one `core_start` cycle.
- **Latency and readback:** stub raises `core_done` in its 100th WAIT cycle; memory[1000..1007]=32'hA0..A7 preloaded → `cycle_count`=101. Digest streams A0..A7 with `dig_index` 0..7 and `dig_last` only on A7.
- **Backpressure:** `dig_ready` low for 5 cycles on index 3 → `dig_data`=A3 held stable, no address change, index 4 follows the handshake.
- **End-to-end:** full run with real `simplified_sha256`, seed 32'h01234567 → digest matches the software SHA-256 of the padded 640-bit message.
- **Timeout:** TIMEOUT=50, `core_done` never asserted → `timeout_err`=1 after 50 WAIT cycles, back in IDLE, no `dig_valid`. The next `go` clears `timeout_err`.
- **Reset and spurious inputs:** reset asserted mid-GEN at k=7 → next cycle IDLE, `mem_we`=0, `busy`=0. `go` and `core_done` pulsed while busy in GEN → ignored.

Source files
------------

// File: rtl/sha256_host_seq.sv
// Host-side sequencer for simplified_sha256: writes a seed-derived message, runs the
// core on the shared memory port, measures its latency and streams the 8-word digest.
module sha256_host_seq #(
  parameter int          NUM_OF_WORDS = 20,
  parameter logic [15:0] MESSAGE_ADDR = 16'd0,
  parameter logic [15:0] OUTPUT_ADDR  = 16'd1000,
  parameter int          TIMEOUT      = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] cycle_count,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  output logic        core_start,
  input  logic        core_done,
  input  logic        core_mem_we,
  input  logic [15:0] core_mem_addr,
  input  logic [31:0] core_mem_write_data,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic [2:0]  dig_index,
  output logic        dig_last,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN    = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RD_REQ = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  localparam logic [6:0]  LAST_K     = 7'(NUM_OF_WORDS - 1);
  localparam logic [31:0] WAIT_LIMIT = 32'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] w;
  logic [6:0]  k;
  logic [2:0]  i;
  logic [31:0] wait_cnt;
  logic        out_first;
  logic [31:0] dig_hold;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] w_rotl;

  assign w_rotl       = {w[30:0], w[31]};
  assign message_addr = MESSAGE_ADDR;
  assign output_addr  = OUTPUT_ADDR;
  assign dig_index    = i;
  assign dbg_state    = state;

  // Digest port: dig_valid rises in OUT and stays high with dig_data/dig_index
  // stable until a cycle where dig_valid && dig_ready; only reset can drop it early.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      w           <= '0;
      k           <= '0;
      i           <= '0;
      wait_cnt    <= '0;
      out_first   <= 1'b0;
      dig_hold    <= '0;
      host_we     <= 1'b0;
      host_addr   <= '0;
      host_wdata  <= '0;
      busy        <= 1'b0;
      core_start  <= 1'b0;
      dig_valid   <= 1'b0;
      dig_last    <= 1'b0;
      timeout_err <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            w           <= seed;
            k           <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            host_we     <= 1'b1;
            host_addr   <= MESSAGE_ADDR;
            host_wdata  <= seed;
            state       <= S_GEN;
          end
        end
        S_GEN: begin
          w <= w_rotl;
          if (k == LAST_K) begin
            host_we    <= 1'b0;
            host_addr  <= '0;
            host_wdata <= '0;
            core_start <= 1'b1;
            state      <= S_START;
          end else begin
            k          <= k + 7'd1;
            host_addr  <= MESSAGE_ADDR + {9'd0, k} + 16'd1;
            // The final message word is forced to zero.
            host_wdata <= (k + 7'd1 == LAST_K) ? 32'h0 : w_rotl;
          end
        end
        S_START: begin
          core_start  <= 1'b0;
          cycle_count <= 32'd1;
          wait_cnt    <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
          if (core_done) begin
            i         <= '0;
            host_addr <= OUTPUT_ADDR;
            state     <= S_RD_REQ;
          end else if (wait_cnt == WAIT_LIMIT) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_RD_REQ: begin
          host_addr <= '0;
          out_first <= 1'b1;
          dig_valid <= 1'b1;
          dig_last  <= (i == 3'd7);
          state     <= S_OUT;
        end
        S_OUT: begin
          out_first <= 1'b0;
          // Memory data is only valid in the first OUT cycle; hold it from then on.
          if (out_first) dig_hold <= mem_read_data;
          if (dig_ready) begin
            dig_valid <= 1'b0;
            dig_last  <= 1'b0;
            if (i == 3'd7) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              i         <= i + 3'd1;
              host_addr <= OUTPUT_ADDR + {13'd0, i} + 16'd1;
              state     <= S_RD_REQ;
            end
          end
        end
        default: begin
          busy       <= 1'b0;
          core_start <= 1'b0;
          dig_valid  <= 1'b0;
          dig_last   <= 1'b0;
          host_we    <= 1'b0;
          host_addr  <= '0;
          host_wdata <= '0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_we         = host_we;
    mem_addr       = host_addr;
    mem_write_data = host_wdata;
    if (state == S_WAIT) begin
      mem_we         = core_mem_we;
      mem_addr       = core_mem_addr;
      mem_write_data = core_mem_write_data;
    end
  end

  assign dig_data = out_first ? mem_read_data : dig_hold;

endmodule
